// File: rtl/ex_mem_stage_reg.sv
// Execute->memory pipeline register with the architectural NZCV flag register.
// Each instruction's condition code is checked against the flags; a failed condition squashes its side effects.
module ex_mem_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [3:0]            in_alu_flags,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_write,
    input  logic                  in_mem_to_reg,
    input  logic                  in_set_flags,
    input  logic [3:0]            in_cond,
    output logic                  cond_pass,
    output logic                  out_valid,
    output logic                  out_squashed,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_write,
    output logic                  out_mem_to_reg,
    output logic [3:0]            flags_q
);

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        cond_pass = 1'b1;
        case (in_cond)
            4'd0:    cond_pass = flag_z;
            4'd1:    cond_pass = !flag_z;
            4'd2:    cond_pass = flag_c;
            4'd3:    cond_pass = !flag_c;
            4'd4:    cond_pass = flag_n;
            4'd5:    cond_pass = !flag_n;
            4'd6:    cond_pass = flag_v;
            4'd7:    cond_pass = !flag_v;
            4'd8:    cond_pass = flag_c && !flag_z;
            4'd9:    cond_pass = !flag_c || flag_z;
            4'd10:   cond_pass = (flag_n == flag_v);
            4'd11:   cond_pass = (flag_n != flag_v);
            4'd12:   cond_pass = !flag_z && (flag_n == flag_v);
            4'd13:   cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;  // AL, and 15 behaves as AL
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_squashed   <= 1'b0;
            out_alu_result <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            flags_q        <= 4'b0000;
        end else if (!stall) begin
            if (flush || !in_valid) begin
                out_valid      <= 1'b0;
                out_squashed   <= 1'b0;
                out_alu_result <= '0;
                out_store_data <= '0;
                out_rd         <= '0;
                out_reg_write  <= 1'b0;
                out_mem_write  <= 1'b0;
                out_mem_to_reg <= 1'b0;
            end else begin
                // A failed condition still travels down the pipe, but with its writes disabled.
                out_valid      <= 1'b1;
                out_squashed   <= !cond_pass;
                out_alu_result <= in_alu_result;
                out_store_data <= in_store_data;
                out_rd         <= in_rd;
                out_reg_write  <= in_reg_write  && cond_pass;
                out_mem_write  <= in_mem_write  && cond_pass;
                out_mem_to_reg <= in_mem_to_reg && cond_pass;
                if (cond_pass && in_set_flags) begin
                    flags_q <= in_alu_flags;
                end
            end
        end
    end

endmodule
